// File: rtl/mem_stage.sv
// Memory stage: runs lw/sw against a req/ack data memory, stalls upstream until done, holds the M/W register.
// Optional MEM_TIMEOUT_EN adds an ACCESS watchdog that forces completion and sets the sticky mem_err.
module mem_stage #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       insn_in,
  input  logic [31:0]       ALU_output_in,
  input  logic [31:0]       data_B_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [31:0]       insn_out,
  output logic [31:0]       ALU_output_out,
  output logic [31:0]       mem_data_out,
  output logic              mem_err
);
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_cap, r_insn, r_alu, r_mdata;
  logic              r_wren;
  logic              w_is_sw, w_is_mem, w_to;

  assign w_is_sw  = (insn_in[31:27] == OP_SW);
  assign w_is_mem = (insn_in[31:27] == OP_LW) | w_is_sw;

  // Gated by reset so the upstream stall drops with reset even while a lw/sw sits on insn_in.
  assign stall    = reset & (((r_state == S_IDLE) & w_is_mem) | (r_state == S_ACCESS));
  assign dmem_req = (r_state == S_ACCESS);

  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign dmem_wren      = r_wren;
  assign insn_out       = r_insn;
  assign ALU_output_out = r_alu;
  assign mem_data_out   = r_mdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // A real ack on the expiry cycle takes precedence over the watchdog.
  assign w_to    = ~dmem_ack & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mem_err = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != S_ACCESS)  r_cnt <= '0;
      else if (!dmem_ack)       r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_ACCESS) && w_to) r_err <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = (TIMEOUT_CYCLES != 0);
  assign w_to     = 1'b0;
  assign mem_err  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wren  <= 1'b0;
      r_cap   <= '0;
      r_insn  <= '0;
      r_alu   <= '0;
      r_mdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            r_addr  <= ALU_output_in[ADDR_W-1:0];
            r_wdata <= data_B_in;
            r_wren  <= w_is_sw;
            r_insn  <= '0;
            r_alu   <= '0;
            r_mdata <= '0;
            r_state <= S_ACCESS;
          end else begin
            r_insn  <= insn_in;
            r_alu   <= ALU_output_in;
            r_mdata <= '0;
          end
        end
        S_ACCESS: begin
          r_insn  <= '0;
          r_alu   <= '0;
          r_mdata <= '0;
          if (dmem_ack) begin
            r_cap   <= r_wren ? 32'd0 : dmem_rdata;
            r_state <= S_DONE;
          end else if (w_to) begin
            r_cap   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // insn_in is still the held memory instruction; it retires here without re-decode.
          r_insn  <= insn_in;
          r_alu   <= ALU_output_in;
          r_mdata <= r_cap;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of non-memory vectors plus hand-written lw/sw, reset and timeout sequences.
module tb_mem_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_in, ALU_output_in, data_B_in, dmem_rdata;
  logic        dmem_ack;
  logic        stall, dmem_req, dmem_wren, mem_err;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata, insn_out, ALU_output_out, mem_data_out;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] LW   = {5'b01000, 27'h0220000};
  localparam logic [31:0] SW   = {5'b00111, 27'h0310000};
  localparam logic [31:0] ADDI = {5'b00101, 27'h0080005};

  mem_stage #(.ADDR_W(12), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .insn_in(insn_in), .ALU_output_in(ALU_output_in),
    .data_B_in(data_B_in), .stall(stall), .dmem_req(dmem_req), .dmem_wren(dmem_wren),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .insn_out(insn_out), .ALU_output_out(ALU_output_out),
    .mem_data_out(mem_data_out), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] alu;
    logic [31:0] exp_insn;
    logic [31:0] exp_alu;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Called just after a posedge. lat = ACCESS cycle (1-based) on which ack is pulsed; 0 = never ack.
  task automatic mem_op(input string nm, input logic [31:0] insn, input logic [31:0] alu,
                        input logic [31:0] b, input logic [31:0] rdata, input int lat,
                        input logic exp_wren, input int exp_stall, input int exp_req,
                        input logic [31:0] exp_mdata);
    int  n_stall = 0;
    int  n_req   = 0;
    bit  stable  = 1;
    bit  bubble  = 1;
    bit  done    = 0;
    insn_in = insn; ALU_output_in = alu; data_B_in = b;
    for (int cyc = 0; cyc < lat + 12 && !done; cyc++) begin
      dmem_ack   = dmem_req && (lat > 0) && (n_req + 1 == lat);
      dmem_rdata = dmem_ack ? rdata : 32'h5555_5555;
      @(negedge clock);
      if (cyc == 0) chk({nm, " req low in decode cycle"}, {31'd0, dmem_req}, 32'd0);
      if (stall) n_stall++;
      if (dmem_req) begin
        n_req++;
        if (dmem_addr !== alu[11:0] || dmem_wdata !== b || dmem_wren !== exp_wren) stable = 0;
      end
      if (n_req > 0 && insn_out !== 32'd0) bubble = 0;
      if (n_req > 0 && !stall) done = 1;
      else begin @(posedge clock); #1; end
    end
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk({nm, " completed within bound"}, {31'd0, done}, 32'd1);
    chk({nm, " stall cycles"}, n_stall, exp_stall);
    chk({nm, " req cycles"}, n_req, exp_req);
    chk({nm, " addr/wdata/wren stable"}, {31'd0, stable}, 32'd1);
    chk({nm, " bubbles during stall"}, {31'd0, bubble}, 32'd1);
    @(posedge clock); #1;
    chk({nm, " insn_out"}, insn_out, insn);
    chk({nm, " ALU_output_out"}, ALU_output_out, alu);
    chk({nm, " mem_data_out"}, mem_data_out, exp_mdata);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{ADDI, 32'h0000_0005, ADDI, 32'h0000_0005};
    vecs[5] = '{32'h0123_4567, 32'hFFFF_F123, 32'h0123_4567, 32'hFFFF_F123};
    vecs[6] = '{32'hF800_0001, 32'h8000_0000, 32'hF800_0001, 32'h8000_0000};

    reset = 1'b0; insn_in = 0; ALU_output_in = 0; data_B_in = 0; dmem_rdata = 0; dmem_ack = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset stall", {31'd0, stall}, 0);
    chk("reset dmem_req", {31'd0, dmem_req}, 0);
    chk("reset dmem_wren", {31'd0, dmem_wren}, 0);
    chk("reset dmem_addr", {20'd0, dmem_addr}, 0);
    chk("reset dmem_wdata", dmem_wdata, 0);
    chk("reset insn_out", insn_out, 0);
    chk("reset ALU_output_out", ALU_output_out, 0);
    chk("reset mem_data_out", mem_data_out, 0);
    chk("reset mem_err", {31'd0, mem_err}, 0);
    tick(); reset = 1'b1;

    foreach (vecs[i]) begin
      insn_in = vecs[i].insn; ALU_output_in = vecs[i].alu; data_B_in = 32'hA5A5_A5A5;
      @(negedge clock);
      chk($sformatf("vec%0d stall", i), {31'd0, stall}, 0);
      chk($sformatf("vec%0d req", i), {31'd0, dmem_req}, 0);
      tick();
      chk($sformatf("vec%0d insn_out", i), insn_out, vecs[i].exp_insn);
      chk($sformatf("vec%0d ALU_output_out", i), ALU_output_out, vecs[i].exp_alu);
      chk($sformatf("vec%0d mem_data_out", i), mem_data_out, 0);
    end

    mem_op("lw fast", LW, 32'h0000_0123, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 2, 1, 32'hDEAD_BEEF);
    insn_in = 0; ALU_output_in = 0; tick();
    mem_op("sw slow", SW, 32'h0000_0040, 32'h0000_CAFE, 32'hFFFF_0000, 5, 1'b1, 6, 5, 32'h0);
    mem_op("b2b lw", LW, 32'h0000_0FFC, 32'h0, 32'h1234_5678, 2, 1'b0, 3, 2, 32'h1234_5678);
    mem_op("b2b sw", SW, 32'hABCD_E008, 32'h7777_0001, 32'h9999_9999, 1, 1'b1, 2, 1, 32'h0);

    // reset in the second ACCESS cycle, stray ack after release
    insn_in = LW; ALU_output_in = 32'h0000_0077; data_B_in = 0;
    tick(); tick();
    chk("pre-reset req", {31'd0, dmem_req}, 1);
    #1 reset = 1'b0;
    #1;
    chk("async reset req", {31'd0, dmem_req}, 0);
    chk("async reset stall", {31'd0, stall}, 0);
    chk("async reset addr", {20'd0, dmem_addr}, 0);
    insn_in = 0; ALU_output_in = 0;
    tick(); reset = 1'b1;
    tick(); dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    chk("stray ack req", {31'd0, dmem_req}, 0);
    chk("stray ack stall", {31'd0, stall}, 0);
    tick(); dmem_ack = 1'b0; dmem_rdata = 0;
    chk("stray ack insn_out", insn_out, 0);
    chk("stray ack mem_data_out", mem_data_out, 0);
    @(negedge clock);
    chk("stray ack no access", {31'd0, dmem_req}, 0);
    tick();

`ifdef MEM_TIMEOUT_EN
    mem_op("timeout lw", LW, 32'h0000_0200, 32'h0, 32'h0, 0, 1'b0, 5, 4, 32'h0);
    chk("timeout mem_err", {31'd0, mem_err}, 1);
    insn_in = 0; ALU_output_in = 0; tick(); tick();
    chk("mem_err sticky", {31'd0, mem_err}, 1);
    #1 reset = 1'b0; #1;
    chk("mem_err cleared by reset", {31'd0, mem_err}, 0);
    tick(); reset = 1'b1;
`else
    chk("mem_err tied low", {31'd0, mem_err}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: got timeout expected finish");
    $fatal(1);
  end
endmodule
